// File: rtl/rv_pkg.sv
// Shared decode constants: opcodes, one-hot class indices, immediate kinds.
// Also holds the registered bundle layout passed from decode to execute.
package rv_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    localparam int OP_LUI     = 0;
    localparam int OP_AUIPC   = 1;
    localparam int OP_JAL     = 2;
    localparam int OP_JALR    = 3;
    localparam int OP_BRANCH  = 4;
    localparam int OP_LOAD    = 5;
    localparam int OP_STORE   = 6;
    localparam int OP_OPIMM   = 7;
    localparam int OP_OP      = 8;
    localparam int OP_FENCE   = 9;
    localparam int OP_SYSTEM  = 10;
    localparam int OP_OPIMM32 = 11;
    localparam int OP_OP32    = 12;
    localparam int OP_N       = 13;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [OP_N-1:0] op;
        logic            illegal;
        logic [11:0]     csr_addr;
        logic [4:0]      csr_uimm;
    } id_ex_t;

    // funct7 values shared by the add/sub and srl/sra pairs
    function automatic logic f7_std(input logic [6:0] f7);
        return (f7 == 7'b0000000) || (f7 == 7'b0100000);
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: selects and sign-extends the immediate to XLEN.
// Built at 64 bits and truncated so one datapath serves RV32 and RV64.
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_t            sel,
    output logic [XLEN-1:0] imm
);

    logic [63:0] full;
    logic        s;

    assign s = instr[31];

    always_comb begin
        full = '0;
        unique case (sel)
            IMM_I: full = {{52{s}}, instr[31:20]};
            IMM_S: full = {{52{s}}, instr[31:25], instr[11:7]};
            IMM_B: full = {{51{s}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
            IMM_U: full = {{32{s}}, instr[31:12], 12'b0};
            IMM_J: full = {{43{s}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
            default: full = '0;
        endcase
    end

    assign imm = full[XLEN-1:0];

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready and flush.
// Define DECODE_ZICSR_EN to accept CSR instructions and expose CSR fields.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic [12:0]     out_op,
    output logic            out_illegal,
    output logic [11:0]     out_csr_addr,
    output logic [4:0]      out_csr_uimm
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [5:0]      f6;
    logic [OP_N-1:0] op_d;
    logic            bad;
    logic            ill_d;
    imm_t            isel;
    logic [XLEN-1:0] imm_d;
    id_ex_t          dec_d;
    id_ex_t          dec_q;
    logic            vld_q;
    logic [PC_W-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            accept;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign f6  = in_instr[31:26];

    always_comb begin
        op_d = '0;
        bad  = 1'b0;
        isel = IMM_NONE;
        unique case (opc)
            OPC_LUI: begin
                op_d[OP_LUI] = 1'b1;
                isel = IMM_U;
            end
            OPC_AUIPC: begin
                op_d[OP_AUIPC] = 1'b1;
                isel = IMM_U;
            end
            OPC_JAL: begin
                op_d[OP_JAL] = 1'b1;
                isel = IMM_J;
            end
            OPC_JALR: begin
                op_d[OP_JALR] = 1'b1;
                isel = IMM_I;
                bad  = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                op_d[OP_BRANCH] = 1'b1;
                isel = IMM_B;
                bad  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                op_d[OP_LOAD] = 1'b1;
                isel = IMM_I;
                bad  = (f3 == 3'b111) ||
                       (!RV64 && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            OPC_STORE: begin
                op_d[OP_STORE] = 1'b1;
                isel = IMM_S;
                bad  = RV64 ? (f3 > 3'b011) : (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                op_d[OP_OPIMM] = 1'b1;
                isel = IMM_I;
                // RV64 frees instr[25] for the sixth shamt bit
                if (f3 == 3'b001)
                    bad = RV64 ? (f6 != 6'b0) : (f7 != 7'b0);
                else if (f3 == 3'b101)
                    bad = RV64 ? !((f6 == 6'b0) || (f6 == 6'b010000))
                               : !f7_std(f7);
            end
            OPC_OP: begin
                op_d[OP_OP] = 1'b1;
                bad = !f7_std(f7) ||
                      (f7[5] && (f3 != 3'b000) && (f3 != 3'b101));
            end
            OPC_FENCE: begin
                op_d[OP_FENCE] = 1'b1;
                isel = IMM_I;
            end
            OPC_SYSTEM: begin
                op_d[OP_SYSTEM] = 1'b1;
                isel = IMM_I;
                if (f3 == 3'b000)
                    bad = (in_instr != INSTR_ECALL) &&
                          (in_instr != INSTR_EBREAK);
                else
`ifdef DECODE_ZICSR_EN
                    bad = (f3 == 3'b100);
`else
                    bad = 1'b1;
`endif
            end
            OPC_OPIMM32: begin
                op_d[OP_OPIMM32] = 1'b1;
                isel = IMM_I;
                if (f3 == 3'b001)
                    bad = !RV64 || (f7 != 7'b0);
                else if (f3 == 3'b101)
                    bad = !RV64 || !f7_std(f7);
                else
                    bad = !RV64 || (f3 != 3'b000);
            end
            OPC_OP32: begin
                op_d[OP_OP32] = 1'b1;
                if (f7 == 7'b0)
                    bad = !RV64 || !((f3 == 3'b000) ||
                          (f3 == 3'b001) || (f3 == 3'b101));
                else
                    bad = !RV64 || (f7 != 7'b0100000) ||
                          !((f3 == 3'b000) || (f3 == 3'b101));
            end
            default: bad = 1'b1;
        endcase
    end

    assign ill_d = bad || (in_instr[1:0] != 2'b11);

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm (
        .instr (in_instr),
        .sel   (isel),
        .imm   (imm_d)
    );

    always_comb begin
        dec_d          = '0;
        dec_d.rd       = in_instr[11:7];
        dec_d.rs1      = in_instr[19:15];
        dec_d.rs2      = in_instr[24:20];
        dec_d.funct3   = f3;
        dec_d.funct7b5 = in_instr[30];
        dec_d.op       = ill_d ? '0 : op_d;
        dec_d.illegal  = ill_d;
`ifdef DECODE_ZICSR_EN
        dec_d.csr_addr = in_instr[31:20];
        dec_d.csr_uimm = in_instr[19:15];
`endif
    end

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;

    // flush outranks accept so a flushed word never reaches execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dec_q <= '0;
            pc_q  <= '0;
            imm_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q <= 1'b1;
            dec_q <= dec_d;
            pc_q  <= in_pc;
            imm_q <= imm_d;
        end else if (out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign out_valid    = vld_q;
    assign out_pc       = pc_q;
    assign out_rd       = dec_q.rd;
    assign out_rs1      = dec_q.rs1;
    assign out_rs2      = dec_q.rs2;
    assign out_funct3   = dec_q.funct3;
    assign out_funct7b5 = dec_q.funct7b5;
    assign out_imm      = imm_q;
    assign out_op       = dec_q.op;
    assign out_illegal  = dec_q.illegal;
    assign out_csr_addr = dec_q.csr_addr;
    assign out_csr_uimm = dec_q.csr_uimm;

endmodule
